// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mips_muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    // Counter must hold the iteration count N = width/bpc itself.
    function automatic int cnt_width(input int width, input int bpc);
        return $clog2(width / bpc + 1);
    endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One combinational iteration: shift-add (multiply) or restoring subtract (divide).
// Multiply: acc:q is the running product, q[0] selects whether to add opnd.
// Divide:   acc is the partial remainder, q shifts the dividend out / quotient in.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Both datapaths are cheap enough to evaluate unconditionally; div_i picks one.
    always_comb begin
        sum     = {1'b0, acc_i} + (q_i[0] ? {1'b0, opnd_i} : '0);
        shifted = {acc_i, q_i[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_i};
        if (div_i) begin
            // Partial remainder is always below the divisor, so the top bit of
            // diff is a clean borrow flag.
            if (!diff[WIDTH]) begin
                acc_o = diff[WIDTH-1:0];
                q_o   = {q_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = shifted[WIDTH-1:0];
                q_o   = {q_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = sum[WIDTH:1];
            q_o   = {sum[0], q_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with start/busy/done handshake.
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = cnt_width(WIDTH, BITS_PER_CYCLE);

    md_state_e        state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q, qr_q, opnd_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             div_q, neg_lo_q, neg_hi_q, dbz_pend_q;
    logic             busy_q, done_q, dbz_q;

    logic             signed_op, is_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;
    logic [WIDTH-1:0] hi_d, lo_d;

    logic [WIDTH-1:0] acc_c [0:BITS_PER_CYCLE];
    logic [WIDTH-1:0] q_c   [0:BITS_PER_CYCLE];

    // Operand decode: signed ops iterate on magnitudes and remember the signs.
    always_comb begin
        signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);
        is_div    = (op_i == MD_DIV) || (op_i == MD_DIVU);
        a_neg     = signed_op & a_i[WIDTH-1];
        b_neg     = signed_op & b_i[WIDTH-1];
        a_mag     = a_neg ? -a_i : a_i;
        b_mag     = b_neg ? -b_i : b_i;
    end

    assign acc_c[0] = acc_q;
    assign q_c[0]   = qr_q;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        muldiv_step #(.WIDTH(WIDTH)) u_step (
            .div_i  (div_q),
            .acc_i  (acc_c[g]),
            .q_i    (q_c[g]),
            .opnd_i (opnd_q),
            .acc_o  (acc_c[g+1]),
            .q_o    (q_c[g+1])
        );
    end

    // Sign fix-up and result selection written to HI/LO in FIX.
    // Divide by zero leaves |a| in the remainder, so the dividend-signed
    // remainder already equals a; only LO needs overriding.
    always_comb begin
        prod_fix = neg_lo_q ? -{acc_q, qr_q} : {acc_q, qr_q};
        quot_fix = neg_lo_q ? -qr_q : qr_q;
        rem_fix  = neg_hi_q ? -acc_q : acc_q;
        hi_d     = prod_fix[2*WIDTH-1:WIDTH];
        lo_d     = prod_fix[WIDTH-1:0];
        if (div_q) begin
            hi_d = rem_fix;
            lo_d = dbz_pend_q ? '1 : quot_fix;
        end
    end

    // Controller, iteration counter and HI/LO registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            qr_q       <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_q      <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dbz_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && !flush_i) begin
                        case (op_i)
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                acc_q      <= '0;
                                qr_q       <= is_div ? a_mag : b_mag;
                                opnd_q     <= is_div ? b_mag : a_mag;
                                div_q      <= is_div;
                                neg_lo_q   <= a_neg ^ b_neg;
                                neg_hi_q   <= a_neg;
                                dbz_pend_q <= is_div && (b_i == '0);
                                dbz_q      <= 1'b0;
                                cnt_q      <= CW'(N);
                                busy_q     <= 1'b1;
                                state_q    <= RUN;
                            end
                            MD_MTHI: begin
                                hi_q   <= a_i;
                                done_q <= 1'b1;
                            end
                            MD_MTLO: begin
                                lo_q   <= a_i;
                                done_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (flush_i) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_c[BITS_PER_CYCLE];
                        qr_q  <= q_c[BITS_PER_CYCLE];
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (!flush_i) begin
                        hi_q   <= hi_d;
                        lo_q   <= lo_d;
                        dbz_q  <= dbz_pend_q;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule
